// File: rtl/rggen_axi4lite_if.sv
// AXI4-Lite bus bundle shared by rggen masters and register blocks.
// ID_WIDTH of 0 still carries a 1-bit ID so the ports always exist.
`timescale 1ns/1ps
interface rggen_axi4lite_if #(
    parameter int ID_WIDTH      = 0,
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    localparam int IDW = (ID_WIDTH > 0) ? ID_WIDTH : 1;

    logic                     awvalid;
    logic                     awready;
    logic [IDW-1:0]           awid;
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [2:0]               awprot;
    logic                     wvalid;
    logic                     wready;
    logic [BUS_WIDTH-1:0]     wdata;
    logic [BUS_WIDTH/8-1:0]   wstrb;
    logic                     bvalid;
    logic                     bready;
    logic [IDW-1:0]           bid;
    logic [1:0]               bresp;
    logic                     arvalid;
    logic                     arready;
    logic [IDW-1:0]           arid;
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [2:0]               arprot;
    logic                     rvalid;
    logic                     rready;
    logic [IDW-1:0]           rid;
    logic [1:0]               rresp;
    logic [BUS_WIDTH-1:0]     rdata;

    modport master (
        output awvalid, awid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb, input wready,
        input  bvalid, bid, bresp, output bready,
        output arvalid, arid, araddr, arprot, input arready,
        input  rvalid, rid, rresp, rdata, output rready
    );

    modport slave (
        input  awvalid, awid, awaddr, awprot, output awready,
        input  wvalid, wdata, wstrb, output wready,
        output bvalid, bid, bresp, input bready,
        input  arvalid, arid, araddr, arprot, output arready,
        output rvalid, rid, rresp, rdata, input rready
    );
endinterface

// File: rtl/rggen_axi4lite_master_bridge.sv
// Single-outstanding AXI4-Lite master driven by a local request/response port.
// Optional ID tracking: define RGGEN_AXI4LITE_MASTER_ID_CHECK_EN.
`timescale 1ns/1ps
module rggen_axi4lite_master_bridge #(
    parameter int ID_WIDTH      = 0,
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32,
    parameter int ID_VALUE      = 0
)(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_write,
    input  logic [ADDRESS_WIDTH-1:0] i_req_address,
    input  logic [2:0]               i_req_prot,
    input  logic [BUS_WIDTH-1:0]     i_req_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_req_strobe,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [1:0]               o_rsp_status,
    output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
    rggen_axi4lite_if.master         axi4lite_if
);
    localparam int IDW = (ID_WIDTH > 0) ? ID_WIDTH : 1;
    localparam logic [IDW-1:0] ID_CONST = IDW'(ID_VALUE);
`ifdef RGGEN_AXI4LITE_MASTER_ID_CHECK_EN
    localparam bit ID_CHECK = (ID_WIDTH > 0);
`else
    localparam bit ID_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, WRITE, WAIT_B, READ, WAIT_R, RESPONSE
    } state_e;

    state_e                   state;
    logic                     awvalid;
    logic                     wvalid;
    logic                     bready;
    logic                     arvalid;
    logic                     rready;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [2:0]               prot;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [BUS_WIDTH/8-1:0]   strobe;
    logic [IDW-1:0]           id_count;
    logic [IDW-1:0]           issued_id;
    logic                     aw_done;
    logic                     w_done;
    logic                     b_id_error;
    logic                     r_id_error;

    assign axi4lite_if.awvalid = awvalid;
    assign axi4lite_if.awid    = ID_CHECK ? issued_id : ID_CONST;
    assign axi4lite_if.awaddr  = address;
    assign axi4lite_if.awprot  = prot;
    assign axi4lite_if.wvalid  = wvalid;
    assign axi4lite_if.wdata   = write_data;
    assign axi4lite_if.wstrb   = strobe;
    assign axi4lite_if.bready  = bready;
    assign axi4lite_if.arvalid = arvalid;
    assign axi4lite_if.arid    = ID_CHECK ? issued_id : ID_CONST;
    assign axi4lite_if.araddr  = address;
    assign axi4lite_if.arprot  = prot;
    assign axi4lite_if.rready  = rready;

    // A channel counts as done once its valid has dropped or it handshakes now.
    assign aw_done    = !awvalid || axi4lite_if.awready;
    assign w_done     = !wvalid  || axi4lite_if.wready;
    assign b_id_error = ID_CHECK && (axi4lite_if.bid != issued_id);
    assign r_id_error = ID_CHECK && (axi4lite_if.rid != issued_id);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            o_req_ready     <= 1'b1;
            o_rsp_valid     <= 1'b0;
            o_rsp_status    <= '0;
            o_rsp_read_data <= '0;
            awvalid         <= 1'b0;
            wvalid          <= 1'b0;
            bready          <= 1'b0;
            arvalid         <= 1'b0;
            rready          <= 1'b0;
            address         <= '0;
            prot            <= '0;
            write_data      <= '0;
            strobe          <= '0;
            id_count        <= '0;
            issued_id       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        o_req_ready <= 1'b0;
                        address     <= i_req_address;
                        prot        <= i_req_prot;
                        write_data  <= i_req_write_data;
                        strobe      <= i_req_strobe;
                        issued_id   <= id_count;
                        id_count    <= id_count + 1'b1;
                        if (i_req_write) begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WRITE;
                        end else begin
                            arvalid <= 1'b1;
                            state   <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (axi4lite_if.awready) awvalid <= 1'b0;
                    if (axi4lite_if.wready)  wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        bready <= 1'b1;
                        state  <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (axi4lite_if.bvalid) begin
                        bready          <= 1'b0;
                        o_rsp_valid     <= 1'b1;
                        o_rsp_status    <= b_id_error ? 2'd2 : axi4lite_if.bresp;
                        o_rsp_read_data <= '0;
                        state           <= RESPONSE;
                    end
                end
                READ: begin
                    if (axi4lite_if.arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (axi4lite_if.rvalid) begin
                        rready          <= 1'b0;
                        o_rsp_valid     <= 1'b1;
                        o_rsp_status    <= r_id_error ? 2'd2 : axi4lite_if.rresp;
                        o_rsp_read_data <= axi4lite_if.rdata;
                        state           <= RESPONSE;
                    end
                end
                RESPONSE: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        o_req_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
